regfile_mp: RTL and testbench

Parametrised multi-port register file with write-back scoreboard, successor to the single-write/dual-read integer register file in the MIPS pipeline core. Provides NREAD combinational read ports, NWRITE synchronous write ports with optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard for ID-stage hazard detection. After reset it runs a one-entry-per-cycle clear sweep so the storage can map to RAM-style arrays without a global reset.

---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_mp_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: legacy register-file
// constants and the INIT/RUN state encoding.
package regfile_mp_pkg;

  localparam int          RegAddrWidth = 5;
  localparam int          RegDataWidth = 32;
  localparam int          RegNum       = 32;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        ReadEnable   = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-write scoreboard: one bit per register, set on issue,
// cleared on write-back, with NREAD lookup ports.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = RegAddrWidth,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NWRITE-1:0]        clr_en,
  input  logic [NWRITE*ADDR_W-1:0] clr_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NREAD*ADDR_W-1:0]  look_addr,
  output logic [NREAD-1:0]         busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Clears are applied before the set so a new producer issued in the same
  // cycle as a write-back of the old one stays pending.
  always_comb begin
    pend_d = pend_q;
    if (rst == RstEnable) begin
      pend_d = '0;
    end else if (run) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (clr_en[k]) pend_d[clr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (set_en && !(ZERO_REG != 0 && set_addr == '0)) pend_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      busy[k] = pend_q[look_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending-write scoreboard
// and a post-reset clear sweep so the array itself needs no reset.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegDataWidth,
  parameter int ADDR_W   = RegAddrWidth,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD-1:0]         re,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_mem [DEPTH];
  logic              run;
  logic              in_rst;
  logic [NWRITE-1:0] wr_ok;
  logic [NREAD-1:0]  byp;
  logic [NREAD-1:0]  sb_busy;

  assign in_rst = (rst == RstEnable);
  assign run    = (state_q == ST_RUN);
  assign ready  = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_rst) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // A write is only real in RUN and outside reset; writes to a hard-wired r0
  // are dropped here so neither the array nor the bypass ever sees them.
  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NWRITE; k++) begin
      wr_ok[k] = run && !in_rst && (we[k] == WriteEnable) &&
                 !(ZERO_REG != 0 && waddr[k*ADDR_W +: ADDR_W] == '0);
    end
  end

  // Later ports are written last, so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs_mem[cnt_q] <= DATA_W'(ZeroWord);
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_ok[k]) regs_mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    ra    = '0;
    val   = '0;
    rdata = '0;
    byp   = '0;
    for (int k = 0; k < NREAD; k++) begin
      ra  = raddr[k*ADDR_W +: ADDR_W];
      val = regs_mem[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_ok[j] && waddr[j*ADDR_W +: ADDR_W] == ra) begin
            byp[k] = 1'b1;
            val    = wdata[j*DATA_W +: DATA_W];
          end
        end
      end
      if (re[k] != ReadEnable || in_rst || !run || (ZERO_REG != 0 && ra == '0)) begin
        val = DATA_W'(ZeroWord);
      end
      rdata[k*DATA_W +: DATA_W] = val;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NREAD   (NREAD),
    .NWRITE  (NWRITE),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (in_rst),
    .run      (run),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .set_en   (sb_set),
    .set_addr (sb_addr),
    .look_addr(raddr),
    .busy     (sb_busy)
  );

  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rbusy[k] = sb_busy[k] && (re[k] == ReadEnable) && run && !in_rst && !byp[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (default build plus a
// non-bypass build sharing the same stimulus).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, ready_nb;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic        sb_set;
  logic [4:0]  sb_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .ready(ready_nb), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        sbs;
    logic [4:0]  sba;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic [31:0] e_nb0;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    we      = v.we;
    waddr   = {v.wa1, v.wa0};
    wdata   = {v.wd1, v.wd0};
    sb_set  = v.sbs;
    sb_addr = v.sba;
    re      = v.re;
    raddr   = {v.ra1, v.ra0};
  endtask

  // Counts cycles with ready low; writes/sb_set are dropped after dropAt cycles.
  task automatic waitReady(input int dropAt, output int n);
    n = 0;
    while (!ready && n < 100) begin
      if (n == dropAt) begin
        we = '0;
        sb_set = 1'b0;
      end
      n++;
      tick();
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,  1'b0, 5'd0, 2'b11, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0};
    vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF};
    vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'h1,        32'h2,  1'b0, 5'd0, 2'b11, 5'd7,  5'd5,  32'h2,        32'hDEADBEEF, 2'b00, 32'h0};
    vecs[3]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,  1'b0, 5'd0, 2'b11, 5'd7,  5'd0,  32'h2,        32'h0,        2'b00, 32'h2};
    vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd0,  5'd7,  32'h0,        32'h2,        2'b00, 32'h0};
    vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b1, 5'd9, 2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h0};
    vecs[7]  = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h55, 1'b0, 5'd0, 2'b01, 5'd9,  5'd9,  32'h55,       32'h0,        2'b00, 32'h0};
    vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd9,  5'd10, 32'h55,       32'h0,        2'b00, 32'h55};
    vecs[9]  = '{2'b01, 5'd9,  5'd0,  32'h66,       32'h0,  1'b1, 5'd9, 2'b11, 5'd9,  5'd10, 32'h66,       32'h0,        2'b00, 32'h55};
    vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd9,  5'd9,  32'h66,       32'h66,       2'b11, 32'h66};
    vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b1, 5'd0, 2'b11, 5'd0,  5'd9,  32'h0,        32'h66,       2'b10, 32'h0};
    vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd0,  5'd9,  32'h0,        32'h66,       2'b10, 32'h0};
    vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b10, 5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
    vecs[14] = '{2'b11, 5'd12, 5'd13, 32'hAA,       32'hBB, 1'b0, 5'd0, 2'b11, 5'd13, 5'd12, 32'hBB,       32'hAA,       2'b00, 32'h0};
    vecs[15] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 2'b11, 5'd12, 5'd13, 32'hAA,       32'hBB,       2'b00, 32'hAA};

    clearInputs();
    rst = 1'b1;
    re = 2'b11;
    raddr = {5'd5, 5'd5};
    repeat (3) tick();
    checkOutput("reset_ready", {31'b0, ready}, 32'h0);
    checkOutput("reset_rdata0", rdata[31:0], 32'h0);
    checkOutput("reset_rdata1", rdata[63:32], 32'h0);
    checkOutput("reset_rbusy", {30'b0, rbusy}, 32'h0);

    rst = 1'b0;
    waitReady(0, n);
    checkOutput("sweep_len", n, 32);
    checkOutput("nb_ready", {31'b0, ready_nb}, 32'h1);

    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      checkOutput($sformatf("clear_r%0d_p0", a), rdata[31:0], 32'h0);
      checkOutput($sformatf("clear_r%0d_p1", a), rdata[63:32], 32'h0);
    end
    tick();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e_rd0);
      checkOutput($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e_rd1);
      checkOutput($sformatf("vec%0d_rbusy", i), {30'b0, rbusy}, {30'b0, vecs[i].e_busy});
      checkOutput($sformatf("vec%0d_nb_rdata0", i), rdata_nb[31:0], vecs[i].e_nb0);
      tick();
    end

    // Write r3, then restart the sweep mid-way and make sure everything is gone.
    clearInputs();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hA};
    tick();
    clearInputs();
    re = 2'b01; raddr = {5'd0, 5'd3};
    #1;
    checkOutput("r3_written", rdata[31:0], 32'hA);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hBAD};
    sb_set = 1'b1; sb_addr = 5'd20;
    re = 2'b11; raddr = {5'd12, 5'd20};
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 9) begin
        checkOutput($sformatf("init%0d_ready", i), {31'b0, ready}, 32'h0);
        checkOutput($sformatf("init%0d_rdata1", i), rdata[63:32], 32'h0);
      end
      tick();
    end

    rst = 1'b1;
    #1;
    checkOutput("midsweep_rst_rdata1", rdata[63:32], 32'h0);
    tick();
    rst = 1'b0;
    waitReady(20, n);
    checkOutput("resweep_len", n, 32);

    clearInputs();
    re = 2'b11; raddr = {5'd20, 5'd3};
    #1;
    checkOutput("post_r3", rdata[31:0], 32'h0);
    checkOutput("post_r20", rdata[63:32], 32'h0);
    checkOutput("post_busy_r3_r20", {30'b0, rbusy}, 32'h0);
    raddr = {5'd12, 5'd9};
    #1;
    checkOutput("post_busy_r9", {30'b0, rbusy}, 32'h0);
    checkOutput("post_r12", rdata[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
